// File: rtl/osc_capture_ctrl.sv
// Oscilloscope capture sequencer: arm, trigger, push a decimated record to the FIFO, then dump it to the UART.
// Build option: define CAPTURE_HEADER_EN to send a 2-byte header (0xA5, {overflow, count[6:0]}) before each dump.
module osc_capture_ctrl #(
    parameter int DATA_W      = 8,
    parameter int CAPTURE_LEN = 256,
    parameter int CNT_W       = 9,
    parameter int DECIM_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  sample,
    input  logic               sample_valid,
    input  logic               arm,
    input  logic               force_trig,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic [DECIM_W-1:0] decim,
    output logic               fifo_push,
    output logic [DATA_W-1:0]  fifo_din,
    output logic               fifo_pop,
    input  logic [DATA_W-1:0]  fifo_dout,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    output logic               tx_start,
    output logic [DATA_W-1:0]  tx_data,
    input  logic               tx_busy,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_CAPTURE, S_POP, S_LOAD, S_SEND, S_WAIT, S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  prev_reg, prev_next;
    logic [DATA_W-1:0]  din_reg, din_next;
    logic [DATA_W-1:0]  tx_data_reg, tx_data_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [DECIM_W-1:0] decim_cnt_reg, decim_cnt_next;
    logic               push_reg, push_next;
    logic               pop_reg, pop_next;
    logic               start_reg, start_next;
    logic               done_reg, done_next;
    logic               busy_reg;
    logic               overflow_reg, overflow_next;
    logic               level_trig;

`ifdef CAPTURE_HEADER_EN
    logic [1:0]         hdr_left_reg, hdr_left_next;
    logic [DATA_W-1:0]  hdr_byte;
    assign hdr_byte = DATA_W'({overflow_reg, count_reg[6:0]});
`endif

    assign level_trig = sample_valid && (prev_reg < trig_level) && (sample >= trig_level);

    always_comb begin
        state_next     = state_reg;
        prev_next      = prev_reg;
        din_next       = din_reg;
        tx_data_next   = tx_data_reg;
        count_next     = count_reg;
        decim_cnt_next = decim_cnt_reg;
        overflow_next  = overflow_reg;
        push_next      = 1'b0;
        pop_next       = 1'b0;
        start_next     = 1'b0;
        done_next      = 1'b0;
`ifdef CAPTURE_HEADER_EN
        hdr_left_next  = hdr_left_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (arm) begin
                    state_next     = S_ARMED;
                    overflow_next  = 1'b0;
                    decim_cnt_next = '0;
                    count_next     = '0;
                    prev_next      = '1;
                end
            end
            S_ARMED: begin
                if (sample_valid)
                    prev_next = sample;
                if (level_trig) begin
                    push_next  = 1'b1;
                    din_next   = sample;
                    count_next = CNT_W'(1);
                    state_next = S_CAPTURE;
                end else if (force_trig) begin
                    count_next = '0;
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (count_reg == CNT_W'(CAPTURE_LEN)) begin
                    state_next = S_POP;
                end else if (sample_valid) begin
                    if (decim_cnt_reg == decim) begin
                        decim_cnt_next = '0;
                        if (fifo_full) begin
                            overflow_next = 1'b1;
                            state_next    = S_POP;
                        end else begin
                            push_next  = 1'b1;
                            din_next   = sample;
                            count_next = count_reg + CNT_W'(1);
                        end
                    end else begin
                        decim_cnt_next = decim_cnt_reg + DECIM_W'(1);
                    end
                end
`ifdef CAPTURE_HEADER_EN
                if (state_next == S_POP)
                    hdr_left_next = 2'd2;
`endif
            end
            S_POP: begin
`ifdef CAPTURE_HEADER_EN
                if (hdr_left_reg != 2'd0) begin
                    tx_data_next  = (hdr_left_reg == 2'd2) ? DATA_W'(8'hA5) : hdr_byte;
                    hdr_left_next = hdr_left_reg - 2'd1;
                    state_next    = S_SEND;
                end else
`endif
                if (fifo_empty) begin
                    state_next = S_DONE;
                end else begin
                    pop_next   = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // The pop strobe is visible during the first LOAD cycle; read data arrives one cycle later.
                if (!pop_reg) begin
                    tx_data_next = fifo_dout;
                    state_next   = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    start_next = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!start_reg && !tx_busy)
                    state_next = S_POP;
            end
            S_DONE: begin
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            prev_reg      <= '0;
            din_reg       <= '0;
            tx_data_reg   <= '0;
            count_reg     <= '0;
            decim_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
            push_reg      <= 1'b0;
            pop_reg       <= 1'b0;
            start_reg     <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef CAPTURE_HEADER_EN
            hdr_left_reg  <= 2'd0;
`endif
        end else begin
            state_reg     <= state_next;
            prev_reg      <= prev_next;
            din_reg       <= din_next;
            tx_data_reg   <= tx_data_next;
            count_reg     <= count_next;
            decim_cnt_reg <= decim_cnt_next;
            overflow_reg  <= overflow_next;
            push_reg      <= push_next;
            pop_reg       <= pop_next;
            start_reg     <= start_next;
            done_reg      <= done_next;
            busy_reg      <= (state_next != S_IDLE);
`ifdef CAPTURE_HEADER_EN
            hdr_left_reg  <= hdr_left_next;
`endif
        end
    end

    assign fifo_push = push_reg;
    assign fifo_din  = din_reg;
    assign fifo_pop  = pop_reg;
    assign tx_start  = start_reg;
    assign tx_data   = tx_data_reg;
    assign done      = done_reg;
    assign busy      = busy_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_osc_capture_ctrl.sv
// Bench for osc_capture_ctrl: FIFO and UART models, record-level reference model, directed plus randomized captures.
module tb_osc_capture_ctrl;
    localparam int DW  = 8;
    localparam int LEN = 16;
    localparam int CW  = 9;
    localparam int DCW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW-1:0]  sample = '0;
    logic           sample_valid = 1'b0;
    logic           arm = 1'b0;
    logic           force_trig = 1'b0;
    logic [DW-1:0]  trig_level = '0;
    logic [DCW-1:0] decim = '0;
    logic           fifo_push, fifo_pop, tx_start, busy, done, overflow;
    logic [DW-1:0]  fifo_din, tx_data;
    logic [DW-1:0]  fifo_dout = '0;
    logic           fifo_full, fifo_empty, tx_busy;

    osc_capture_ctrl #(.DATA_W(DW), .CAPTURE_LEN(LEN), .CNT_W(CW), .DECIM_W(DCW)) dut (
        .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid), .arm(arm),
        .force_trig(force_trig), .trig_level(trig_level), .decim(decim),
        .fifo_push(fifo_push), .fifo_din(fifo_din), .fifo_pop(fifo_pop), .fifo_dout(fifo_dout),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // FIFO model
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] push_log[$];
    int            fifo_cnt = 0;
    logic          force_full = 1'b0;
    logic          fifo_flush = 1'b0;
    assign fifo_empty = (fifo_cnt == 0);
    assign fifo_full  = force_full || (fifo_cnt >= 64);

    always @(posedge clk) begin
        if (fifo_flush) fifo_q.delete();
        if (fifo_push) begin
            fifo_q.push_back(fifo_din);
            push_log.push_back(fifo_din);
        end
        if (fifo_pop && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
        fifo_cnt <= fifo_q.size();
    end

    // UART model
    logic          uart_busy = 1'b0;
    logic          busy_hold = 1'b0;
    int            busy_len = 4;
    int            busy_left = 0;
    logic [DW-1:0] tx_latched = '0;
    logic [DW-1:0] tx_log[$];
    int            bad_start = 0, unstable = 0, pop_busy = 0, done_cnt = 0;
    assign tx_busy = uart_busy | busy_hold;

    always @(posedge clk) begin
        if (tx_start) begin
            tx_log.push_back(tx_data);
            if (tx_busy) bad_start <= bad_start + 1;
            uart_busy  <= 1'b1;
            busy_left  <= busy_len;
            tx_latched <= tx_data;
        end else if (uart_busy) begin
            if (!rst && tx_data !== tx_latched) unstable <= unstable + 1;
            if (busy_left <= 1) uart_busy <= 1'b0;
            else busy_left <= busy_left - 1;
        end
        if (fifo_pop && tx_busy) pop_busy <= pop_busy + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int            tests = 0, fails = 0;
    logic [DW-1:0] fed_q[$];
    logic [DW-1:0] exp_q[$];
    int            push_base = 0, tx_base = 0, done_base = 0, full_after = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Record-level model: first rising crossing (or a forced start) opens the record,
    // then every (dec+1)-th valid sample is kept until 'limit' samples are kept.
    function automatic void build_expected(input logic [DW-1:0] lvl, input int dec, input bit forced, input int limit);
        int  prev = 255;
        int  k = 0;
        bit  trig = forced;
        exp_q.delete();
        foreach (fed_q[i]) begin
            if (exp_q.size() >= limit) break;
            if (!trig) begin
                if (prev < int'(lvl) && int'(fed_q[i]) >= int'(lvl)) begin
                    trig = 1;
                    exp_q.push_back(fed_q[i]);
                    k = 0;
                end
                prev = int'(fed_q[i]);
            end else if (k == dec) begin
                exp_q.push_back(fed_q[i]);
                k = 0;
            end else begin
                k++;
            end
        end
    endfunction

    task automatic do_arm(input string tag);
        @(negedge clk);
        push_base = push_log.size();
        tx_base   = tx_log.size();
        done_base = done_cnt;
        fed_q.delete();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check({tag, " busy after arm"}, busy, 1);
        check({tag, " overflow cleared"}, overflow, 0);
    endtask

    task automatic feed(input int n, input bit ramp, input logic [DW-1:0] start_val, input int gap_pct);
        logic [DW-1:0] v = start_val;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (full_after > 0 && (push_log.size() - push_base + int'(fifo_push)) >= full_after)
                force_full = 1'b1;
            sample       = v;
            sample_valid = 1'b1;
            fed_q.push_back(v);
            if (ramp) v = v + 8'd1;
            if ($urandom_range(0, 99) < gap_pct) begin
                @(negedge clk);
                sample_valid = 1'b0;
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done_cnt == done_base && t < 6000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check({tag, " done seen"}, done_cnt - done_base, 1);
    endtask

    task automatic verify_run(input string tag, input bit exp_ovf);
        int np = push_log.size() - push_base;
        int nt = tx_log.size() - tx_base;
        logic [DW-1:0] txe[$];
        check({tag, " push count"}, np, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < np; i++)
            check($sformatf("%s push[%0d]", tag, i), push_log[push_base + i], exp_q[i]);
`ifdef CAPTURE_HEADER_EN
        txe.push_back(8'hA5);
        txe.push_back({exp_ovf, 7'(exp_q.size())});
`endif
        foreach (exp_q[i]) txe.push_back(exp_q[i]);
        check({tag, " tx count"}, nt, txe.size());
        for (int i = 0; i < txe.size() && i < nt; i++)
            check($sformatf("%s tx[%0d]", tag, i), tx_log[tx_base + i], txe[i]);
        check({tag, " overflow"}, overflow, exp_ovf);
        check({tag, " busy idle"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " fifo_push"}, fifo_push, 0);
        check({tag, " fifo_pop"}, fifo_pop, 0);
        check({tag, " tx_start"}, tx_start, 0);
        check({tag, " done"}, done, 0);
        check({tag, " overflow"}, overflow, 0);
        check({tag, " tx_data"}, tx_data, 0);
        check({tag, " fifo_din"}, fifo_din, 0);
    endtask

    task automatic ramp_capture(input string tag, input logic [DW-1:0] lvl, input int dec,
                                input logic [DW-1:0] start_val, input int n, input int gap);
        trig_level = lvl;
        decim      = DCW'(dec);
        do_arm(tag);
        feed(n, 1'b1, start_val, gap);
        build_expected(lvl, dec, 1'b0, LEN);
        wait_done(tag);
        verify_run(tag, 1'b0);
    endtask

    initial begin
        int t;
        int starts;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Ramp through the threshold, no decimation
        ramp_capture("ramp", 8'h80, 0, 8'h00, 256, 20);

        // Constant stream above threshold never crosses; force starts the record
        trig_level = 8'h80;
        decim      = '0;
        do_arm("force");
        feed(40, 1'b0, 8'h90, 10);
        check("force no push while armed", push_log.size() - push_base, 0);
        check("force still busy", busy, 1);
        force_trig = 1'b1;
        @(negedge clk);
        force_trig = 1'b0;
        fed_q.delete();
        feed(40, 1'b0, 8'h90, 10);
        build_expected(8'h80, 0, 1'b1, LEN);
        wait_done("force");
        verify_run("force", 1'b0);

        // Decimation by 3
        ramp_capture("decim2", 8'h10, 2, 8'h00, 120, 15);

        // FIFO full after the fifth push
        trig_level = 8'h40;
        decim      = DCW'(1);
        do_arm("ovf");
        full_after = 5;
        feed(160, 1'b1, 8'h00, 10);
        build_expected(8'h40, 1, 1'b0, 5);
        wait_done("ovf");
        verify_run("ovf", 1'b1);
        full_after = 0;
        force_full = 1'b0;
        repeat (5) @(negedge clk);
        check("ovf sticky after done", overflow, 1);

        // Randomized captures (do_arm checks overflow cleared)
        for (int r = 0; r < 3; r++)
            ramp_capture($sformatf("rand%0d", r), DW'($urandom_range(8'h20, 8'hE0)),
                         int'($urandom_range(0, 3)), DW'($urandom_range(0, 255)), 600, 30);

        // Slow UART: 100 busy cycles per byte
        busy_len = 100;
        ramp_capture("slow", 8'h80, 0, 8'h00, 256, 10);
        check("slow bad starts", bad_start, 0);
        check("slow pop while busy", pop_busy, 0);
        check("slow tx_data unstable", unstable, 0);

        // Reset while waiting in SEND
        trig_level = 8'h80;
        decim      = '0;
        do_arm("rst");
        feed(256, 1'b1, 8'h00, 10);
        busy_len = 3;
        t = 0;
        while (!fifo_pop && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("rst pop seen", fifo_pop, 1);
        busy_hold = 1'b1;
        starts = tx_log.size();
        repeat (10) @(negedge clk);
        check("rst no start while held", tx_log.size() - starts, 0);
        check("rst busy before reset", busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst async");
        @(negedge clk);
        check_reset_outputs("rst held");
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        busy_hold  = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        ramp_capture("after rst", 8'h80, 0, 8'h00, 256, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
